// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared loader state type and sizing helper for the config path
package config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/config_word_serializer.sv
// rtl/config_word_serializer.sv - parallel-load right-shift PISO for one host word
module config_word_serializer
  import config_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic                  bit_o,
  output logic                  last_bit_o
);

  localparam int IDX_W = (clog2(WORD_WIDTH) > 0) ? clog2(WORD_WIDTH) : 1;

  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  // A load wins over a shift so the next word can follow the last bit with no bubble
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load_i) begin
      shreg_d = data_i;
      idx_d   = '0;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
      idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign bit_o      = shreg_q[0];
  assign last_bit_o = (idx_q == IDX_W'(WORD_WIDTH - 1));

endmodule

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - sequences a full serial load of the fabric config chain
module config_chain_loader
  import config_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 96
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int COUNT_WIDTH = clog2(CHAIN_LENGTH + 1);

  loader_state_e          state_q, state_d;
  logic [COUNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   in_shift;
  logic                   final_bit;
  logic                   ser_bit;
  logic                   ser_last;

  assign in_shift  = (state_q == ST_SHIFT);
  assign final_bit = in_shift && (bit_cnt_q == COUNT_WIDTH'(CHAIN_LENGTH - 1));

  // The final chain bit suppresses the refill request even mid-word
  assign word_ready    = (state_q == ST_FETCH) || (in_shift && ser_last && !final_bit);
  assign config_enable = in_shift;
  assign config_out    = in_shift & ser_bit;
  assign busy          = (state_q == ST_FETCH) || in_shift;
  assign done          = done_q;
  assign error         = error_q;

  config_word_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_serializer (
    .clock_i   (clock),
    .reset_i   (reset),
    .load_i    (word_valid && word_ready),
    .shift_i   (in_shift),
    .data_i    (word_data),
    .bit_o     (ser_bit),
    .last_bit_o(ser_last)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = done_q;
    error_d   = error_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_FETCH;
          bit_cnt_d = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        if (start) error_d = 1'b1;
        if (word_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (start) error_d = 1'b1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (final_bit) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (ser_last && !word_valid) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - self-checking bench for config_chain_loader
module tb_config_chain_loader;

  localparam int WW  = 8;
  localparam int CL0 = 20;
  localparam int CL1 = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset         [2];
  logic          start         [2];
  logic [WW-1:0] word_data     [2];
  logic          word_valid    [2];
  logic          word_ready    [2];
  logic          config_out    [2];
  logic          config_enable [2];
  logic          busy          [2];
  logic          done          [2];
  logic          error         [2];

  config_chain_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL0)) dut20 (
    .clock(clock), .reset(reset[0]), .start(start[0]),
    .word_data(word_data[0]), .word_valid(word_valid[0]), .word_ready(word_ready[0]),
    .config_out(config_out[0]), .config_enable(config_enable[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0])
  );

  config_chain_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL1)) dut16 (
    .clock(clock), .reset(reset[1]), .start(start[1]),
    .word_data(word_data[1]), .word_valid(word_valid[1]), .word_ready(word_ready[1]),
    .config_out(config_out[1]), .config_enable(config_enable[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1])
  );

  int checks = 0;
  int errors = 0;

  // Host script for the next load: words and cycles valid is withheld before each
  logic [WW-1:0] hw [$];
  int            hd [$];

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic add_word(input logic [WW-1:0] w, input int dly);
    hw.push_back(w);
    hd.push_back(dly);
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++)
      add_word(WW'($urandom), (i == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 11)));
  endtask

  task automatic check_quiet(input int d, input string tag, input logic exp_done);
    check_bit($sformatf("%s/ready", tag), word_ready[d], 1'b0);
    check_bit($sformatf("%s/enable", tag), config_enable[d], 1'b0);
    check_bit($sformatf("%s/busy", tag), busy[d], 1'b0);
    check_bit($sformatf("%s/done", tag), done[d], exp_done);
  endtask

  task automatic idle_valid(input int d, input string tag, input logic exp_done);
    word_valid[d] = 1'b1;
    word_data[d]  = 8'hC3;
    repeat (4) begin
      @(negedge clock);
      check_quiet(d, tag, exp_done);
    end
    word_valid[d] = 1'b0;
  endtask

  // err_bit: pulse start while that chain bit is on config_out; abort_bit: assert reset there
  task automatic run_load(input int d, input int err_bit, input int abort_bit, input string tag);
    int cl, nneed, bubbles, b, exp_ready, exp_busy;
    int en_cnt, low_cnt, busy_cnt, ready_cnt, hs_cnt, last_en, wait_c, widx, cyc;
    logic [31:0] obs_stream, exp_stream;
    logic [WW-1:0] w, extra;
    bit finished;

    cl    = (d == 0) ? CL0 : CL1;
    nneed = (cl + WW - 1) / WW;

    // Expected load: words concatenated LSB-first and cut at the chain length
    exp_stream = '0;
    for (int i = 0; i < cl; i++) begin
      w = hw[i / WW];
      exp_stream[i] = w[i % WW];
    end
    // A later word withheld past the WW-1 cycles of the previous word stalls the chain
    bubbles   = 0;
    exp_ready = hd[0] + 1;
    for (int i = 1; i < nneed; i++) begin
      b = (hd[i] > WW - 1) ? hd[i] - (WW - 1) : 0;
      bubbles   += b;
      exp_ready += 1 + b;
    end
    exp_busy = hd[0] + 1 + cl + bubbles;

    extra = WW'($urandom);
    en_cnt = 0; low_cnt = 0; busy_cnt = 0; ready_cnt = 0; hs_cnt = 0;
    last_en = -100; widx = 0; wait_c = hd[0]; obs_stream = '0; finished = 0;

    @(negedge clock);
    start[d]      = 1'b1;
    word_valid[d] = 1'b0;
    @(negedge clock);
    check_bit($sformatf("%s/done_cleared", tag), done[d], 1'b0);
    check_bit($sformatf("%s/error_cleared", tag), error[d], 1'b0);

    for (cyc = 0; cyc < 400; cyc++) begin
      start[d] = 1'b0;
      if (done[d]) begin
        finished = 1;
        break;
      end
      if (busy[d]) busy_cnt++;
      if (word_ready[d]) ready_cnt++;
      if (config_enable[d]) begin
        if (en_cnt < 32) obs_stream[en_cnt] = config_out[d];
        if (en_cnt == abort_bit) begin
          reset[d]      = 1'b1;
          word_valid[d] = 1'b0;
          hw.delete();
          hd.delete();
          return;
        end
        if (en_cnt == err_bit) start[d] = 1'b1;
        en_cnt++;
        last_en = cyc;
      end else if (busy[d] && en_cnt > 0) begin
        low_cnt++;
      end
      word_data[d]  = (widx < hw.size()) ? hw[widx] : extra;
      word_valid[d] = (wait_c == 0);
      if (word_valid[d] && word_ready[d]) begin
        hs_cnt++;
        widx++;
        wait_c = (widx < hd.size()) ? hd[widx] : 0;
      end else if (wait_c > 0) begin
        wait_c--;
      end
      @(negedge clock);
    end

    word_valid[d] = 1'b0;
    check_int($sformatf("%s/finished", tag), int'(finished), 1);
    check_int($sformatf("%s/stream", tag), int'(obs_stream), int'(exp_stream));
    check_int($sformatf("%s/enable_cycles", tag), en_cnt, cl);
    check_int($sformatf("%s/gap_cycles", tag), low_cnt, bubbles);
    check_int($sformatf("%s/busy_cycles", tag), busy_cnt, exp_busy);
    check_int($sformatf("%s/ready_cycles", tag), ready_cnt, exp_ready);
    check_int($sformatf("%s/handshakes", tag), hs_cnt, nneed);
    check_int($sformatf("%s/done_latency", tag), cyc - last_en, 1);
    check_bit($sformatf("%s/error", tag), error[d], (err_bit >= 0) ? 1'b1 : 1'b0);
    check_quiet(d, $sformatf("%s/end", tag), 1'b1);
    hw.delete();
    hd.delete();
  endtask

  initial begin
    int d, eb;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; start[i] = 1'b0; word_valid[i] = 1'b0; word_data[i] = '0;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check_quiet(i, $sformatf("reset%0d", i), 1'b0);
      check_bit($sformatf("reset%0d/error", i), error[i], 1'b0);
      check_bit($sformatf("reset%0d/config_out", i), config_out[i], 1'b0);
      reset[i] = 1'b0;
    end

    idle_valid(0, "idle_valid_after_reset", 1'b0);

    add_word(8'hA5, 0); add_word(8'h3C, 0); add_word(8'h0F, 0);
    run_load(0, -1, -1, "l20_directed");

    add_word(8'hFF, 0); add_word(8'h00, WW - 1 + 3);
    run_load(1, -1, -1, "l16_gap3");

    add_word(8'h12, 0); add_word(8'h34, 0);
    run_load(1, -1, -1, "l16_b2b");

    add_random(3);
    run_load(0, 5, -1, "l20_start_bit5");

    add_random(3);
    run_load(0, CL0 - 1, -1, "l20_start_final");

    add_random(3);
    run_load(0, -1, -1, "l20_clear");

    add_random(3);
    run_load(0, 3, 10, "l20_reset_bit10");
    @(negedge clock);
    check_quiet(0, "reset_mid_load", 1'b0);
    check_bit("reset_mid_load/error", error[0], 1'b0);
    reset[0] = 1'b0;
    add_random(3);
    run_load(0, -1, -1, "l20_after_reset");

    idle_valid(1, "idle_valid_after_done", 1'b1);

    for (int k = 0; k < 8; k++) begin
      d = int'($urandom_range(0, 1));
      add_random((d == 0) ? 3 : 2);
      eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, ((d == 0) ? CL0 : CL1) - 1)) : -1;
      run_load(d, eb, -1, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Sequences programming of the fabric configuration shift chain. This is the chain that holds, among others, the 3-bit selector fields of every switchbox/interconnect multiplexer.
- Accepts configuration words from a host over a valid/ready handshake and serializes them LSB-first onto the chain head.
- Drives the chain-wide shift enable and reports busy, done and misuse.
- Sits between the bitstream source (host bridge or boot ROM reader) and the top-level config chain.

Parameters:
- WORD_WIDTH, 8, width of each host configuration word.
- CHAIN_LENGTH, 96, total number of configuration flops in the chain (bits to shift per load).
- COUNT_WIDTH, derived localparam = clog2(CHAIN_LENGTH+1), width of the bit counter. Not overridable.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a full chain load.
- word_data  input  WORD_WIDTH  configuration word from host.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  loader accepts word_data this cycle.
- config_out  output  1  serial bit to chain head.
- config_enable  output  1  chain shift enable; the chain shifts one position per cycle while high.
- busy  output  1  high from accepted start until the load completes.
- done  output  1  high after a complete load, held until the next accepted start or reset.
- error  output  1  sticky: start was asserted while busy.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; shift register, bit counter and word bit index cleared.
  - All outputs 0 the cycle after reset is sampled high.
  - Chain contents are not cleared; the loader simply stops shifting.
- States: IDLE, FETCH, SHIFT, DONE. busy=1 in FETCH and SHIFT only.
- IDLE / DONE:
  - word_ready=0, config_enable=0.
  - start=1 → FETCH; bit counter=0, done←0, error←0.
- FETCH:
  - word_ready=1, config_enable=0.
  - On word_valid&word_ready: latch word into shift register, word bit index=0 → SHIFT.
- SHIFT, every cycle:
  - config_enable=1 and config_out=shreg[0], both from flops (no combinational path from inputs).
  - Next edge: shreg shifts right by one, word index+1, bit counter+1.
- Exits from SHIFT, in priority order:
  - Bit counter reaches CHAIN_LENGTH-1 on this cycle (final chain bit): → DONE, done←1. Any unsent bits of the current word are discarded and word_ready stays 0.
  - Otherwise, word index = WORD_WIDTH-1 (last bit of word): word_ready=1 this cycle.
    - If word_valid: next word is loaded, remain in SHIFT, no bubble.
    - Else: → FETCH. config_enable drops to 0 and the chain holds.
- Latency: first config_enable cycle is 1 cycle after the first accepted word. With continuous word_valid, the load takes exactly CHAIN_LENGTH enable cycles plus 1 fetch cycle.
- Chain ordering: the first bit shifted (word 0 bit 0) ends in the flop farthest from the head.
- start while busy: ignored (load continues), error←1.
- start and the final-bit cycle coincide: treated as busy; error set, load completes normally.
- word_valid is ignored when word_ready=0. word_data must be stable while word_valid=1 and word_ready=0.
- reset mid-load: the load is abandoned and the chain is left partially shifted. The host must restart.

Decomposition:
- Shared package (config_pkg): loader state enum typedef (IDLE, FETCH, SHIFT, DONE) and a clog2 constant function reused by other config-path blocks.
- One natural sub-module: config_word_serializer. It is a WORD_WIDTH parallel-load, right-shift PISO with load/shift controls and a last_bit flag. The FSM and bit counter remain in config_chain_loader.

Test Plan (WORD_WIDTH=8 unless noted):
- CHAIN_LENGTH=20; start, then words 0xA5, 0x3C, 0x0F with valid held → 20 consecutive enable cycles. config_out = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1. done=1 next cycle; upper nibble of 0x0F never driven; word_ready never high after the third handshake.
- CHAIN_LENGTH=16; valid withheld for 3 cycles between words 0xFF and 0x00 → enable low for exactly those gap cycles. 16 total enable cycles; done=1; busy high throughout.
- start pulsed during SHIFT at bit 5 → error=1 and stays 1. Bit stream and enable count unchanged; next start after done clears error and done.
- reset asserted at bit 10 of a 20-bit load → next cycle: config_enable=0, word_ready=0, busy=0, done=0, error=0. Fresh start performs a full 20-bit load.
- CHAIN_LENGTH=16 with 0x12, 0x34 back-to-back → word_ready high on the fetch cycle and on bit 7 only. 16 enable cycles without a bubble; not high after bit 15.
- word_valid asserted in IDLE with no start → word_ready stays 0, no enable, state unchanged.
